i2c_master_sched: RTL and testbench

//  Single-byte I2C master that shares one SDA/SCL bus among NREQ requesters.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_master_sched_rr_arbiter.sv | 31 +++
 rtl/i2c_master_sched.sv | 188 ++++++++++++++++++
 tb/tb_i2c_master_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the scheduled single-byte I2C master.
// Transaction states, quarter-slot encodings and ACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    WDATA,
    ACK2,
    RDATA,
    MNACK,
    STOP,
    DONE
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_master_sched_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping modulo NREQ, returned one-hot.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_master_sched.sv
// Single-byte I2C master shared by NREQ round-robin requesters.
// One START/addr/data/STOP transaction per grant.
module i2c_master_sched
  import i2c_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              nack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              scl,
  inout  wire               sda
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t          state, state_n;
  logic [DW-1:0]   div;
  logic [1:0]      q;
  logic [2:0]      bitcnt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0] gnt_w, grant_r;
  logic [6:0]      addr_r, addr_w;
  logic            rw_r, rw_w;
  logic [7:0]      wdata_r, wdata_w;
  logic [7:0]      rx_r, rdata_r, tx;
  logic            smp, nack_acc, nack_r;
  logic            scl_r, scl_n, low_r, low_n;
  logic            qtick, slot_end, start_txn;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(gnt_w)
  );

  assign qtick     = (div == DW'(CLK_DIV - 1));
  assign slot_end  = qtick && (q == Q3);
  assign start_txn = (state == IDLE) && (|req);
  assign tx        = {addr_r, rw_r};

  always_comb begin
    addr_w  = '0;
    rw_w    = 1'b0;
    wdata_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_w[i]) begin
        addr_w  = req_addr[7*i +: 7];
        rw_w    = req_rw[i];
        wdata_w = req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_r[i]) ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_txn) state_n = START;
      START: if (slot_end) state_n = ADDR;
      ADDR:  if (slot_end && bitcnt == 3'd0) state_n = ACK1;
      ACK1:  if (slot_end) begin
        if (smp == I2C_NACK) state_n = STOP;
        else                 state_n = rw_r ? RDATA : WDATA;
      end
      WDATA: if (slot_end && bitcnt == 3'd0) state_n = ACK2;
      ACK2:  if (slot_end) state_n = STOP;
      RDATA: if (slot_end && bitcnt == 3'd0) state_n = MNACK;
      MNACK: if (slot_end) state_n = STOP;
      STOP:  if (slot_end) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus levels per quarter; registered below so scl/sda never glitch.
  always_comb begin
    scl_n = 1'b1;
    low_n = 1'b0;
    case (state)
      START: begin
        scl_n = (q != Q3);
        low_n = (q != Q0);
      end
      ADDR: begin
        scl_n = (q == Q1) || (q == Q2);
        low_n = !tx[bitcnt];
      end
      WDATA: begin
        scl_n = (q == Q1) || (q == Q2);
        low_n = !wdata_r[bitcnt];
      end
      ACK1, ACK2, RDATA, MNACK: begin
        scl_n = (q == Q1) || (q == Q2);
      end
      STOP: begin
        scl_n = (q != Q0);
        low_n = (q == Q0) || (q == Q1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      q        <= Q0;
      bitcnt   <= 3'd7;
      ptr      <= '0;
      grant_r  <= '0;
      addr_r   <= '0;
      rw_r     <= 1'b0;
      wdata_r  <= '0;
      rx_r     <= '0;
      rdata_r  <= '0;
      smp      <= I2C_ACK;
      nack_acc <= I2C_ACK;
      nack_r   <= 1'b0;
      scl_r    <= 1'b1;
      low_r    <= 1'b0;
    end else begin
      scl_r <= scl_n;
      low_r <= low_n;
      if (start_txn) begin
        grant_r  <= gnt_w;
        addr_r   <= addr_w;
        rw_r     <= rw_w;
        wdata_r  <= wdata_w;
        div      <= '0;
        q        <= Q0;
        bitcnt   <= 3'd7;
        nack_acc <= I2C_ACK;
        rx_r     <= '0;
      end else if (state == DONE) begin
        grant_r <= '0;
        ptr     <= ptr_nxt;
      end else if (state != IDLE) begin
        div <= qtick ? '0 : div + 1'b1;
        if (qtick) q <= q + 2'd1;
        if (qtick && q == Q2) begin
          smp <= sda;
          if (state == RDATA) rx_r <= {rx_r[6:0], sda};
        end
        // bitcnt wraps 0 -> 7, ready for the next byte
        if (slot_end) begin
          if (state == ADDR || state == WDATA || state == RDATA)
            bitcnt <= bitcnt - 3'd1;
          if (state == ACK1 || state == ACK2)
            nack_acc <= nack_acc | smp;
          if (state == STOP) begin
            nack_r  <= nack_acc;
            rdata_r <= rx_r;
          end
        end
      end
    end
  end

  assign grant = grant_r;
  assign done  = (state == DONE) ? grant_r : '0;
  assign busy  = (state != IDLE);
  assign nack  = nack_r;
  assign rdata = rdata_r;
  assign scl   = scl_r;
  assign sda   = low_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_sched.sv
// Bench for i2c_master_sched: slave model at 7'h50 plus a
// scoreboard of expected transaction outcomes.
module tb_i2c_master_sched;

  localparam int NREQ    = 2;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'h50;
  localparam logic [7:0] SLV_RD   = 8'hCC;

  localparam int S_IDLE = 0;
  localparam int S_ADDR = 1;
  localparam int S_AACK = 2;
  localparam int S_WR   = 3;
  localparam int S_DACK = 4;
  localparam int S_RD   = 5;
  localparam int S_MACK = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   grant, done;
  logic              nack, busy, scl;
  logic [7:0]        rdata;
  wire               sda;

  pullup (sda);

  i2c_master_sched #(.NREQ(NREQ), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_addr(req_addr),
    .req_rw(req_rw),
    .req_wdata(req_wdata),
    .grant(grant),
    .done(done),
    .nack(nack),
    .rdata(rdata),
    .busy(busy),
    .scl(scl),
    .sda(sda)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Slave model
  int         ph = S_IDLE;
  int         cnt = 0;
  int         rises = 0;
  logic [7:0] sh = '0;
  bit         rd = 1'b0;
  bit         slv_low = 1'b0;
  bit         mack = 1'b0;
  bit         scl_q = 1'b1;
  bit         sda_q = 1'b1;
  logic [7:0] bus_q[$];

  assign sda = (slv_low && rst_n) ? 1'b0 : 1'bz;

  always @(negedge clk) begin : slave
    logic s_scl, s_sda;
    s_scl = scl;
    s_sda = sda;
    if (!rst_n) begin
      ph      = S_IDLE;
      slv_low = 1'b0;
    end else if (s_scl && scl_q && sda_q && !s_sda) begin
      ph      = S_ADDR;
      cnt     = 0;
      rises   = 0;
      mack    = 1'b0;
      slv_low = 1'b0;
      bus_q.delete();
    end else if (s_scl && scl_q && !sda_q && s_sda) begin
      ph      = S_IDLE;
      slv_low = 1'b0;
    end else if (s_scl && !scl_q) begin
      rises++;
      if (ph == S_ADDR || ph == S_WR || ph == S_RD) begin
        sh = {sh[6:0], s_sda};
        cnt++;
        if (cnt == 8) bus_q.push_back(sh);
      end
      if (ph == S_MACK) mack = s_sda;
    end else if (!s_scl && scl_q) begin
      case (ph)
        S_ADDR: if (cnt == 8) begin
          if (sh[7:1] == SLV_ADDR) begin
            slv_low = 1'b1;
            rd      = sh[0];
            ph      = S_AACK;
          end else begin
            ph = S_IDLE;
          end
        end
        S_AACK: begin
          cnt = 0;
          if (rd) begin
            ph      = S_RD;
            slv_low = !SLV_RD[7];
          end else begin
            ph      = S_WR;
            slv_low = 1'b0;
          end
        end
        S_WR: if (cnt == 8) begin
          slv_low = 1'b1;
          ph      = S_DACK;
        end
        S_DACK: begin
          slv_low = 1'b0;
          ph      = S_IDLE;
        end
        S_RD: if (cnt == 8) begin
          slv_low = 1'b0;
          ph      = S_MACK;
        end else begin
          slv_low = !sh_bit(SLV_RD, 7 - cnt);
        end
        S_MACK: ph = S_IDLE;
        default: ;
      endcase
    end
    scl_q = s_scl;
    sda_q = s_sda;
  end

  function automatic bit sh_bit(input logic [7:0] v, input int i);
    return v[i[2:0]];
  endfunction

  // Scoreboard
  typedef struct {
    int         idx;
    bit         rw;
    bit         nack;
    int         lat;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   t_grant = 0;
  int   n_done = 0;
  int   multi = 0;
  logic [NREQ-1:0] grant_q = '0;

  always @(posedge clk) cyc++;

  function automatic exp_t mk_exp(input int idx, input logic [6:0] a,
                                  input bit rw, input logic [7:0] wd);
    exp_t e;
    e.idx    = idx;
    e.rw     = rw;
    e.nack   = (a != SLV_ADDR);
    e.lat    = e.nack ? 44 * CLK_DIV : 80 * CLK_DIV;
    e.nbytes = e.nack ? 1 : 2;
    e.b0     = {a, rw};
    e.b1     = rw ? SLV_RD : wd;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if ($countones(grant) > 1) multi++;
      if (grant != '0 && grant_q == '0) t_grant = cyc;
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          e = sb.pop_front();
          check("done_idx", 32'(done), 32'(1 << e.idx));
          check("grant_at_done", 32'(grant), 32'(1 << e.idx));
          check("busy_at_done", 32'(busy), 1);
          check("nack", 32'(nack), 32'(e.nack));
          check("latency", cyc - t_grant, e.lat);
          check("bus_nbytes", bus_q.size(), e.nbytes);
          if (bus_q.size() > 0) check("bus_byte0", 32'(bus_q[0]), 32'(e.b0));
          if (e.nbytes > 1 && bus_q.size() > 1)
            check("bus_byte1", 32'(bus_q[1]), 32'(e.b1));
          if (e.rw && !e.nack) begin
            check("rdata", 32'(rdata), 32'(SLV_RD));
            check("master_nack", 32'(mack), 1);
          end
        end
        req = req & ~done;
        n_done++;
      end
    end
    grant_q = grant;
  end

  task automatic load(input int idx, input logic [6:0] a, input bit rw,
                      input logic [7:0] wd);
    req_addr[7*idx +: 7]  = a;
    req_rw[idx]           = rw;
    req_wdata[8*idx +: 8] = wd;
  endtask

  task automatic wait_done(input int target, input int budget,
                           input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(n_done >= target), 1);
  endtask

  task automatic txn(input int idx, input logic [6:0] a, input bit rw,
                     input logic [7:0] wd, input bit drop);
    int k;
    int target;
    sb.push_back(mk_exp(idx, a, rw, wd));
    load(idx, a, rw, wd);
    target = n_done + 1;
    @(negedge clk);
    req[idx] = 1'b1;
    if (drop) begin
      k = 0;
      while (!grant[idx] && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("drop_grant", 32'(grant[idx]), 1);
      req[idx] = 1'b0;
    end
    wait_done(target, 100 * CLK_DIV + 50, "done_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int k;
    int target;
    int n_before;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_nack", 32'(nack), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_scl", 32'(scl), 1);
    check("rst_sda", 32'(sda), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    txn(0, 7'h50, 1'b0, 8'hA5, 1'b0);
    txn(1, 7'h50, 1'b1, 8'h00, 1'b0);

    repeat (2) begin
      sb.push_back(mk_exp(0, 7'h50, 1'b0, 8'h11));
      sb.push_back(mk_exp(1, 7'h50, 1'b0, 8'h22));
      load(0, 7'h50, 1'b0, 8'h11);
      load(1, 7'h50, 1'b0, 8'h22);
      target = n_done + 2;
      @(negedge clk);
      req = 2'b11;
      wait_done(target, 200 * CLK_DIV + 100, "contend_timeout");
      repeat (3) @(negedge clk);
    end

    txn(0, 7'h23, 1'b0, 8'h5A, 1'b0);
    txn(0, 7'h50, 1'b0, 8'h3C, 1'b1);

    load(1, 7'h50, 1'b1, 8'h00);
    rises = 0;
    @(negedge clk);
    req[1] = 1'b1;
    k = 0;
    while (rises < 14 && k < 100 * CLK_DIV) begin
      @(negedge clk);
      k++;
    end
    check("rd_bit3_reached", 32'(rises >= 14), 1);
    n_before = n_done;
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    check("mid_rst_scl", 32'(scl), 1);
    check("mid_rst_sda", 32'(sda), 1);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", n_done, n_before);

    txn(0, 7'h50, 1'b0, 8'h96, 1'b0);

    repeat (5) @(negedge clk);
    check("grant_onehot", multi, 0);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
